dmem_mmio_responder: RTL
========================

// Module: dmem_mmio_responder
// PURPOSE
//  Memory-side responder for the single-cycle MIPS data port (memwrite/memaddr/memwritedata/memreaddata).
//  Provides word RAM plus an MMIO page: a compare timer with interrupt, and a byte console TX FIFO
//  with a valid/ready drain port. Reads are combinational, because the CPU consumes data in the same cycle.
//  Writes commit on the rising clk edge.
// PARAMETERS
//  RAM_AW      6         RAM word-address width (2**RAM_AW words, indexed by memaddr[RAM_AW+1:2])
//  FIFO_DEPTH  4         console FIFO entries; power of 2, 2..16
//  MMIO_BASE   16'hFFFF  memaddr[31:16] value that selects the MMIO page
// PORTS
//  clk           in   1   clock; all state updates on the rising edge
//  reset         in   1   synchronous, active-high reset
//  memwrite      in   1   CPU store strobe, sampled at the clk edge
//  memaddr       in   32  byte address; bits [1:0] ignored (word access only)
//  memwritedata  in   32  store data
//  memreaddata   out  32  load data; combinational from memaddr
//  tx_data       out  8   FIFO head byte
//  tx_valid      out  1   FIFO non-empty
//  tx_ready      in   1   consumer accepts head when tx_valid & tx_ready at clk edge
//  timer_irq     out  1   STAT.match & CTRL.irq_en (registered terms only)
// BEHAVIOUR
//  Decode: mmio = (memaddr[31:16]==MMIO_BASE); otherwise the access goes to RAM (upper bits aliased).
//  MMIO offsets are memaddr[7:0]:
//   0x00 CNT  R/W 32b; a write loads the counter.      0x04 CMP  R/W 32b.
//   0x08 CTRL R/W bit0 en, bit1 irq_en.                0x0C STAT bit0 match; write-1-clears.
//   0x10 TXD  W: push memwritedata[7:0]; reads 0.
//   0x14 TXS  R: bit0 full, bit1 empty, bit2 ovf, [7:4] count; W: bit2=1 clears ovf.
//   Unmapped offsets read 0; writes to them are ignored. Reads never have side effects.
//  Reset: CNT=CMP=CTRL=STAT=0, FIFO empty, ovf=0, tx_valid=0, tx_data=0, timer_irq=0.
//   RAM contents are not initialised; a read before the first write returns X.
//  Timer, per cycle with en=1:
//   - CNT==CMP: CNT<=0 and match<=1 (auto-reload).
//   - Otherwise CNT<=CNT+1, wrapping 32'hFFFFFFFF->0.
//   - With en=0, CNT holds.
//  Timer precedence:
//   - A CPU write to CNT overrides increment/reload that cycle.
//   - A match event that coincides with a STAT W1C leaves match=1 (set wins).
//  FIFO:
//   - Push on memwrite to TXD. Accepted if count<FIFO_DEPTH, or if a pop occurs the same edge.
//   - Otherwise the byte is dropped and ovf<=1. Same-edge ovf set and clear: set wins.
//   - Pop on tx_valid & tx_ready. Pop on empty is a no-op.
//   - Push+pop together: count unchanged, order preserved.
//   - tx_data shows the head entry and stays stable while tx_valid & ~tx_ready.
//   - A byte pushed into an empty FIFO appears on tx_valid one cycle after the write edge.
//   - Pointers wrap modulo FIFO_DEPTH.
//  RAM: memwrite & ~mmio writes the full word at the edge. Read-during-write returns old data (combinational read).
//  Reset mid-operation: asserting reset in any cycle discards FIFO contents and timer state at that edge.
//   The RAM write for that cycle is still performed.
// CONFIGURATION
//  CONSOLE_FIFO_EN defined: console FIFO and tx_* port operate as specified above.
//  CONSOLE_FIFO_EN undefined: no FIFO storage. TXD writes are ignored; TXS reads 32'h0000_0002 (empty only).
//   tx_valid=0 and tx_data=0 constantly; tx_ready is ignored. Timer and RAM are unchanged.
// TESTING
//  1 Store 0xDEADBEEF @0x00000040, load @0x00000040 next cycle -> memreaddata=0xDEADBEEF.
//    Load @0x00000140 (RAM_AW=6 alias) -> 0xDEADBEEF.
//  2 CMP=3, CTRL=3 -> CNT reads 1,2,3 then 0.
//    STAT=1 and timer_irq=1 from the edge after CNT==3.
//    Write STAT=1 -> timer_irq=0 until the next match, 4 cycles later.
//  3 tx_ready=0, push 0x41..0x45 (5 bytes) -> TXS=0x45 (count 4, full, ovf).
//    tx_data=0x41 holds. Then tx_ready=1 -> 0x41,0x42,0x43,0x44 on consecutive cycles, then tx_valid=0.
//  4 FIFO full with tx_ready=1, push 0x55 same cycle -> accepted, no ovf; 0x55 drains last.
//  5 Write CNT=0xFFFFFFFF with CMP=0, en=1 -> CNT wraps to 0 with no match.
//    The next cycle matches (CNT==CMP=0).
//  6 Assert reset for 1 cycle with FIFO at 3 entries and CNT running -> tx_valid=0, CNT=0, TXS=0x02, timer_irq=0.
//    Build without CONSOLE_FIFO_EN: TXD write -> tx_valid stays 0, TXS=0x02.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for a single-cycle MIPS core: word RAM plus an MMIO page holding a
// compare timer and a console TX FIFO. Define CONSOLE_FIFO_EN to build the console FIFO.
module dmem_mmio_responder #(
   parameter int          RAM_AW     = 6,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic [31:0] memreaddata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam logic [5:0] OFF_CNT  = 6'h00;
   localparam logic [5:0] OFF_CMP  = 6'h01;
   localparam logic [5:0] OFF_CTRL = 6'h02;
   localparam logic [5:0] OFF_STAT = 6'h03;
   localparam logic [5:0] OFF_TXD  = 6'h04;
   localparam logic [5:0] OFF_TXS  = 6'h05;

   logic              mmio;
   logic [5:0]        reg_sel;
   logic [RAM_AW-1:0] ram_idx;
   logic              wr_ram, wr_cnt, wr_cmp, wr_ctrl, wr_stat, wr_txd, wr_txs;
   logic [31:0]       txs;

   assign mmio    = (memaddr[31:16] == MMIO_BASE);
   assign reg_sel = memaddr[7:2];
   assign ram_idx = memaddr[RAM_AW+1:2];
   assign wr_ram  = memwrite & ~mmio;
   assign wr_cnt  = memwrite & mmio & (reg_sel == OFF_CNT);
   assign wr_cmp  = memwrite & mmio & (reg_sel == OFF_CMP);
   assign wr_ctrl = memwrite & mmio & (reg_sel == OFF_CTRL);
   assign wr_stat = memwrite & mmio & (reg_sel == OFF_STAT);
   assign wr_txd  = memwrite & mmio & (reg_sel == OFF_TXD);
   assign wr_txs  = memwrite & mmio & (reg_sel == OFF_TXS);

   // ---------------- word RAM ----------------
   logic [31:0] ram [2**RAM_AW];

   // NOTE: storage arrays get no reset; the RAM write also ignores reset so a store in a reset cycle lands.
   always_ff @(posedge clk) begin
      if (wr_ram) ram[ram_idx] <= memwritedata;
   end

   // ---------------- compare timer ----------------
   logic [31:0] cnt, cmp;
   logic        en, irq_en, match, hit;

   assign hit = en & (cnt == cmp);

   // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         cmp    <= '0;
         en     <= 1'b0;
         irq_en <= 1'b0;
         match  <= 1'b0;
      end else begin
         if (wr_cnt)   cnt <= memwritedata;
         else if (hit) cnt <= '0;
         else if (en)  cnt <= cnt + 32'd1;
         if (wr_cmp) cmp <= memwritedata;
         if (wr_ctrl) begin
            en     <= memwritedata[0];
            irq_en <= memwritedata[1];
         end
         // A CNT write only overrides the counter update; the match flag still records the hit.
         if (hit)                          match <= 1'b1;
         else if (wr_stat & memwritedata[0]) match <= 1'b0;
      end
   end

   assign timer_irq = match & irq_en;

   // ---------------- console TX FIFO ----------------
`ifdef CONSOLE_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          ovf, full, pop, push_ok, push_drop;
   logic [3:0]    count_field;

   assign full      = (count == CW'(FIFO_DEPTH));
   assign tx_valid  = (count != '0);
   assign pop       = tx_valid & tx_ready;
   // A pop on the same edge frees the slot the push needs.
   assign push_ok   = wr_txd & (~full | pop);
   assign push_drop = wr_txd & ~push_ok;
   assign tx_data   = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= memwritedata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         if (push_ok & ~pop)      count <= count + CW'(1);
         else if (pop & ~push_ok) count <= count - CW'(1);
         if (push_drop)                     ovf <= 1'b1;
         else if (wr_txs & memwritedata[2]) ovf <= 1'b0;
      end
   end

   // The 4-bit count field truncates at depth 16; the full bit disambiguates.
   assign count_field = 4'(count);
   assign txs = {24'h0, count_field, 1'b0, ovf, ~tx_valid, full};
`else
   logic unused_fifo;

   assign tx_valid    = 1'b0;
   assign tx_data     = 8'h00;
   assign txs         = 32'h0000_0002;
   assign unused_fifo = &{1'b0, tx_ready, wr_txd, wr_txs};
`endif

   logic unused_addr;
   assign unused_addr = &{1'b0, memaddr[1:0], memaddr[15:8]};

   // ---------------- read mux ----------------
   // NOTE: default assignment first keeps this combinational block latch-free.
   always_comb begin
      memreaddata = '0;
      if (!mmio) begin
         memreaddata = ram[ram_idx];
      end else begin
         case (reg_sel)
            OFF_CNT:  memreaddata = cnt;
            OFF_CMP:  memreaddata = cmp;
            OFF_CTRL: memreaddata = {30'h0, irq_en, en};
            OFF_STAT: memreaddata = {31'h0, match};
            OFF_TXS:  memreaddata = txs;
            default:  memreaddata = '0;
         endcase
      end
   end

endmodule
